// File: rtl/des_pkg.sv
// des_pkg: shared DES tables (E, P, S1..S8), the f-function FSM state type and the E/P wiring helpers.
package des_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SUBST, ST_DONE} state_e;

  // Entries are 1-based FIPS bit numbers of the source word (bit 1 = MSB).
  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box is stored row-major: index = {row, column}.
  localparam logic [3:0] S_TAB [8][64] = '{
    '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
      4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
      4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
      4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
    '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
      4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
      4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
      4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
    '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
      4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
      4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
      4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
    '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
      4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
      4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
      4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
    '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
      4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
      4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
      4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
    '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
      4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
      4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
      4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
    '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
      4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
      4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
      4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
    '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
      4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
      4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
      4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
  };

  function automatic logic [47:0] e_expand(input logic [31:0] r);
    logic [47:0] e;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TAB[i]];
    return e;
  endfunction

  function automatic logic [31:0] p_permute(input logic [31:0] s);
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
    return p;
  endfunction

endpackage

// File: rtl/des_sbox_lookup.sv
// des_sbox_lookup: combinational S-box lookup; row = {g[5],g[0]}, column = g[4:1].
module des_sbox_lookup
  import des_pkg::*;
(
  input  logic [2:0] box_sel,
  input  logic [5:0] group,
  output logic [3:0] sbox_out
);
  assign sbox_out = S_TAB[box_sel][{group[5], group[0], group[4:1]}];
endmodule

// File: rtl/des_f_function.sv
// des_f_function: iterative DES round function f(R,K) = P(S(E(R) xor K)), one S-box per cycle.
module des_f_function
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] r_half,
  input  logic [47:0] subkey,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] f_output,
  output logic        out_valid,
  input  logic        out_ready
);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [47:0] x_q, x_d;
  logic [31:0] acc_q, acc_d, f_q, f_d;
  logic [5:0]  grp;
  logic [3:0]  s_val;
  always_comb begin
    grp = x_q[47:42];
    for (int i = 1; i < 8; i++) if (cnt_q == 3'(i)) grp = x_q[47-6*i -: 6];
  end
  des_sbox_lookup u_sbox (
    .box_sel (cnt_q),
    .group   (grp),
    .sbox_out(s_val)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    acc_d   = acc_q;
    f_d     = f_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) begin
        x_d     = e_expand(r_half) ^ subkey;
        cnt_d   = '0;
        acc_d   = '0;
        state_d = ST_SUBST;
      end
      ST_SUBST: begin
        acc_d = {acc_q[27:0], s_val};
        // counter parks at 7; only a new accept restarts it
        cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          f_d     = p_permute(acc_d);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
    end
  end
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign f_output  = f_q;
endmodule

// File: tb/tb_des_f_function.sv
// tb_des_f_function: directed and random checks of des_f_function against an independent DES f model.
module tb_des_f_function;
  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] r_half, f_output;
  logic [47:0] subkey;
  int checks = 0;
  int failures = 0;

  des_f_function dut (
    .clk(clk), .reset(reset), .r_half(r_half), .subkey(subkey),
    .in_valid(in_valid), .in_ready(in_ready), .f_output(f_output),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  localparam int ME [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                             16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int MP [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int MS [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] m_x(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    for (int n = 1; n <= 48; n++) e[48-n] = r[32-ME[n-1]];
    return e ^ k;
  endfunction

  function automatic logic [31:0] m_sub(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  g;
    for (int b = 0; b < 8; b++) begin
      g = x[47-6*b -: 6];
      s[31-4*b -: 4] = 4'(MS[b][2*g[5]+g[0]][g[4:1]]);
    end
    return s;
  endfunction

  function automatic logic [31:0] m_perm(input logic [31:0] s);
    logic [31:0] p;
    for (int n = 1; n <= 32; n++) p[32-n] = s[32-MP[n-1]];
    return p;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    return m_perm(m_sub(m_x(r, k)));
  endfunction

  task automatic accept(input logic [31:0] r, input logic [47:0] k);
    r_half = r; subkey = k; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts rising edges from the accept edge (inclusive) until out_valid is seen
  task automatic wait_valid(output int lat, input bit rnd, input bit scramble);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (scramble) begin
        r_half = $urandom; subkey = {16'($urandom), $urandom}; in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat, n;
    logic [31:0] r, f0;
    logic [47:0] k;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; r_half = '0; subkey = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_f_output", f_output, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    accept(32'hF0AAF0AA, 48'h1B02EFFC7072);
    check("fips_x", dut.x_q, 48'h6117BA866527);
    check("fips_in_ready_busy", in_ready, 1'b0);
    wait_valid(lat, 1'b0, 1'b0);
    check("fips_latency", lat, 9);
    check("fips_acc", dut.acc_q, 32'h5C82B597);
    check("fips_f", f_output, 32'h234AA9BB);
    check("model_fips", m_f(32'hF0AAF0AA, 48'h1B02EFFC7072), 32'h234AA9BB);
    release_out("fips");

    accept(32'h0, 48'h0);
    wait_valid(lat, 1'b0, 1'b0);
    check("zero_latency", lat, 9);
    check("zero_acc", dut.acc_q, 32'hEFA72C4D);
    check("zero_f", f_output, m_perm(32'hEFA72C4D));
    release_out("zero");

    accept(32'h12345678, 48'h0123456789AB);
    wait_valid(lat, 1'b0, 1'b0);
    f0 = f_output;
    check("bp_f", f0, m_f(32'h12345678, 48'h0123456789AB));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_f_stable", f_output, f0);
      check("bp_valid_hold", out_valid, 1'b1);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    release_out("bp");
    accept(32'hCAFEBABE, 48'hA5A5_5A5A_0F0F);
    check("bp_next_accept", in_ready, 1'b0);
    wait_valid(lat, 1'b0, 1'b0);
    check("bp_next_latency", lat, 9);
    check("bp_next_f", f_output, m_f(32'hCAFEBABE, 48'hA5A5_5A5A_0F0F));
    release_out("bp_next");

    accept(32'hDEADBEEF, 48'h112233445566);
    repeat (4) @(negedge clk);
    check("rst4_cnt", dut.cnt_q, 3'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst4_in_ready", in_ready, 1'b1);
    check("rst4_out_valid", out_valid, 1'b0);
    check("rst4_f", f_output, 32'h0);
    check("rst4_cnt_clr", dut.cnt_q, 3'd0);
    check("rst4_acc_clr", dut.acc_q, 32'h0);
    check("rst4_x_clr", dut.x_q, 48'h0);
    reset = 1'b1; in_valid = 1'b1; r_half = 32'h1; subkey = 48'h1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_prio_dropped", in_ready, 1'b1);
    accept(32'h89ABCDEF, 48'hFEDCBA987654);
    wait_valid(lat, 1'b0, 1'b0);
    check("post_rst_latency", lat, 9);
    check("post_rst_f", f_output, m_f(32'h89ABCDEF, 48'hFEDCBA987654));
    release_out("post_rst");

    accept(32'h0F0F0F0F, 48'h3C3C3C3C3C3C);
    wait_valid(lat, 1'b0, 1'b1);
    check("chg_latency", lat, 9);
    check("chg_f", f_output, m_f(32'h0F0F0F0F, 48'h3C3C3C3C3C3C));
    release_out("chg");
    repeat (3) @(negedge clk);
    check("chg_no_second_op", out_valid, 1'b0);
    check("chg_still_idle", in_ready, 1'b1);

    for (int t = 0; t < 1000; t++) begin
      r = $urandom; k = {16'($urandom), $urandom};
      accept(r, k);
      wait_valid(lat, 1'b1, 1'b0);
      check("rnd_latency", lat, 9);
      check("rnd_f", f_output, m_f(r, k));
      n = 0;
      out_ready = 1'b0;
      while (out_valid && n < 20) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      out_ready = 1'b0;
      check("rnd_drained", out_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
